rtc_port_regbank_p: RTL and testbench
=====================================

// Module: rtc_port_regbank_p
// PURPOSE
//   Parametrised register bank between the soft-processor I/O port bus (Port_ID/Out_Port/In_Port)
//   and the RTC controller. Processor writes go to shadow registers and reach the RTC only on an
//   atomic commit. RTC readback values are captured as a coherent snapshot. A commit FSM handles
//   the RTC-write handshake with a timeout. Sticky status flags clear when the processor reads them.
// PARAMETERS
//   DATA_W    8      width of each channel register and of Out_Port/In_Port
//   NCH       9      number of channels (year, month, day, h, m, s, timer h/m/s)
//   WR_BASE   8'h02  Port_ID of write channel 0; channel i at WR_BASE+i
//   CTRL_ADDR 8'h0B  control register (write-only)
//   RD_BASE   8'h0C  Port_ID of snapshot channel 0; channel i at RD_BASE+i
//   STAT_ADDR 8'h15  status register (read, clear-on-read)
//   TIMEOUT   1023   cycles in WAIT_DONE before error; counter width $clog2(TIMEOUT+1)
//   Address ranges must not overlap and must fit in 8 bits (checked at elaboration).
// PORTS
//   clk         in   1            system clock, rising edge
//   reset       in   1            asynchronous, active-low reset
//   write       in   1            Out_Port valid for Port_ID this cycle
//   read_strobe in   1            processor consumed In_Port for Port_ID this cycle
//   Port_ID     in   8            port address
//   Out_Port    in   DATA_W       processor write data
//   In_Port     out  DATA_W       registered read data
//   rd_bus      in   NCH*DATA_W   live RTC values; channel i at [i*DATA_W +: DATA_W]
//   rtc_done    in   1            RTC write finished (level; rising edge is used)
//   wr_bus      out  NCH*DATA_W   committed values to the RTC; same packing
//   commit_req  out  1            one-cycle pulse: wr_bus updated, RTC must write it
//   Listo_esc   out  1            high while FSM is IDLE (ready to accept a commit)
// BEHAVIOUR
//   Reset: all shadow, wr_bus, snapshot and status registers 0. In_Port=0. commit_req=0. FSM=IDLE,
//     so Listo_esc=1. Timeout counter=0. rtc_done edge-detect register=0.
//   Shadow write: write && Port_ID==WR_BASE+i -> shadow[i]<=Out_Port at the next edge. Allowed in any state.
//   Control write (write && Port_ID==CTRL_ADDR): bit0=commit, bit1=snapshot. Other bits are ignored.
//   Snapshot: bit1 -> snap[i]<=rd_bus slice on that same edge for all i, and snap_valid<=1.
//     Processor reads then return snap[], never live values.
//   FSM IDLE: on commit, wr_bus<=shadow (all channels on the same edge) and go to PULSE.
//   FSM PULSE: commit_req=1 for exactly this one cycle. Clear the counter and go to WAIT_DONE.
//   FSM WAIT_DONE: on an rtc_done rising edge, set done_sticky and go to IDLE.
//     Otherwise the counter increments each cycle. When the counter reaches TIMEOUT, set err and go to IDLE.
//   Commit outside IDLE: ignored, wr_bus unchanged, ovr<=1.
//   Commit with snapshot in the same write: both actions are performed.
//   rtc_done edge in the same cycle as timeout: the done edge wins (done_sticky=1, err=0).
//   Read path: In_Port<=mux(Port_ID) on every edge, giving 1-cycle latency.
//     RD_BASE+i returns snap[i].
//     STAT_ADDR returns {0.., err, ovr, snap_valid, done_sticky, busy}, with busy = FSM!=IDLE at bit0.
//     Any unmapped Port_ID returns 0.
//   Clear-on-read: read_strobe && Port_ID==STAT_ADDR clears done_sticky, err and ovr at that edge.
//     A flag set on the same edge survives the clear.
//   snap_valid clears only on reset.
//   Reset mid-WAIT_DONE: immediately IDLE with everything 0. Any pending RTC write is abandoned.
// TESTING
//   1. Hold reset low, then release -> In_Port=0, wr_bus=0, commit_req=0, Listo_esc=1, status read=8'h00.
//   2. Write 8'h13 to Port_ID 8'h02 and 8'h57 to 8'h0A, with no commit -> wr_bus unchanged (0).
//      Then write 8'h01 to 8'h0B -> ch0=8'h13 and ch8=8'h57 appear together, commit_req pulses exactly
//      1 cycle, Listo_esc=0.
//   3. During WAIT_DONE, write 8'h01 to 8'h0B again -> wr_bus unchanged, status bit3(ovr)=1.
//      Then raise rtc_done -> Listo_esc=1, status=8'h0A.
//      Read status with read_strobe -> next status read gives 8'h00.
//   4. rd_bus ch5=8'h43, then write 8'h02 to 8'h0B, then change rd_bus ch5 to 8'h44
//      -> Port_ID 8'h11 returns 8'h43 one cycle after the address, and snap_valid=1.
//   5. Commit with rtc_done held low -> after TIMEOUT cycles, FSM returns to IDLE and status bit4(err)=1.
//      Also: rtc_done held high through the commit, with no new rising edge, still times out.
//   6. Assert reset in WAIT_DONE -> Listo_esc=1 asynchronously, wr_bus=0; Port_ID 8'hFF returns 0.

Source files
------------

// File: rtl/rtc_port_regbank_p.sv
// rtc_port_regbank_p: port-bus register bank with shadowed atomic commit to the RTC,
// coherent readback snapshot, timed commit handshake and clear-on-read status.
module rtc_port_regbank_p #(
   parameter int         DATA_W    = 8,
   parameter int         NCH       = 9,
   parameter logic [7:0] WR_BASE   = 8'h02,
   parameter logic [7:0] CTRL_ADDR = 8'h0B,
   parameter logic [7:0] RD_BASE   = 8'h0C,
   parameter logic [7:0] STAT_ADDR = 8'h15,
   parameter int         TIMEOUT   = 1023
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  write,
   input  logic                  read_strobe,
   input  logic [7:0]            Port_ID,
   input  logic [DATA_W-1:0]     Out_Port,
   output logic [DATA_W-1:0]     In_Port,
   input  logic [NCH*DATA_W-1:0] rd_bus,
   input  logic                  rtc_done,
   output logic [NCH*DATA_W-1:0] wr_bus,
   output logic                  commit_req,
   output logic                  Listo_esc
);
   localparam int CW     = $clog2(TIMEOUT + 1);
   localparam int WR_END = int'(WR_BASE) + NCH - 1;
   localparam int RD_END = int'(RD_BASE) + NCH - 1;

   function automatic bit in_rng(input int x, input int lo, input int hi);
      return x >= lo && x <= hi;
   endfunction

   localparam bit CFG_OK = DATA_W >= 5 && NCH >= 1 && TIMEOUT >= 1 && WR_END < 256 && RD_END < 256
      && (WR_END < int'(RD_BASE) || RD_END < int'(WR_BASE))
      && !in_rng(int'(CTRL_ADDR), int'(WR_BASE), WR_END) && !in_rng(int'(CTRL_ADDR), int'(RD_BASE), RD_END)
      && !in_rng(int'(STAT_ADDR), int'(WR_BASE), WR_END) && !in_rng(int'(STAT_ADDR), int'(RD_BASE), RD_END)
      && CTRL_ADDR != STAT_ADDR;

   if (!CFG_OK) begin : g_cfg_err
      $error("rtc_port_regbank_p: invalid parameters or overlapping address map");
   end

   typedef enum logic [1:0] {IDLE, PULSE, WAIT_DONE} state_t;

   state_t                  r_state, w_next;
   logic [CW-1:0]           r_cnt;
   logic [NCH*DATA_W-1:0]   r_shadow, r_wr_bus, r_snap;
   logic [DATA_W-1:0]       r_in_port, w_rd_data;
   logic                    r_done_q, r_done_sticky, r_err, r_ovr, r_snap_valid;
   logic [NCH-1:0]          w_wr_hit, w_rd_hit;
   logic                    w_ctrl, w_commit, w_snap, w_clr, w_rise, w_timeout, w_busy;
   logic                    w_set_done, w_set_err, w_set_ovr;

   assign w_ctrl     = write && Port_ID == CTRL_ADDR;
   assign w_commit   = w_ctrl && Out_Port[0];
   assign w_snap     = w_ctrl && Out_Port[1];
   assign w_clr      = read_strobe && Port_ID == STAT_ADDR;
   assign w_rise     = rtc_done && !r_done_q;
   assign w_timeout  = r_cnt == CW'(TIMEOUT);
   assign w_busy     = r_state != IDLE;
   // done edge takes priority over a simultaneous timeout
   assign w_set_done = r_state == WAIT_DONE && w_rise;
   assign w_set_err  = r_state == WAIT_DONE && !w_rise && w_timeout;
   assign w_set_ovr  = w_commit && w_busy;

   always_comb begin
      for (int i = 0; i < NCH; i++) begin
         w_wr_hit[i] = write && Port_ID == 8'(int'(WR_BASE) + i);
         w_rd_hit[i] = Port_ID == 8'(int'(RD_BASE) + i);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:      w_next = w_commit ? PULSE : IDLE;
         PULSE:     w_next = WAIT_DONE;
         WAIT_DONE: w_next = (w_rise || w_timeout) ? IDLE : WAIT_DONE;
         default:   w_next = IDLE;
      endcase
   end

   always_comb begin
      commit_req = r_state == PULSE;
      Listo_esc  = r_state == IDLE;
   end

   always_comb begin
      w_rd_data = '0;
      if (Port_ID == STAT_ADDR) w_rd_data[4:0] = {r_err, r_ovr, r_snap_valid, r_done_sticky, w_busy};
      for (int i = 0; i < NCH; i++)
         if (w_rd_hit[i]) w_rd_data = r_snap[i*DATA_W +: DATA_W];
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_shadow      <= '0;
         r_wr_bus      <= '0;
         r_snap        <= '0;
         r_in_port     <= '0;
         r_cnt         <= '0;
         r_done_q      <= 1'b0;
         r_done_sticky <= 1'b0;
         r_err         <= 1'b0;
         r_ovr         <= 1'b0;
         r_snap_valid  <= 1'b0;
      end else begin
         for (int i = 0; i < NCH; i++)
            if (w_wr_hit[i]) r_shadow[i*DATA_W +: DATA_W] <= Out_Port;
         if (r_state == IDLE && w_commit) r_wr_bus <= r_shadow;
         if (w_snap) r_snap <= rd_bus;
         r_snap_valid  <= r_snap_valid | w_snap;
         r_in_port     <= w_rd_data;
         r_cnt         <= (r_state == PULSE) ? '0 :
                          (r_state == WAIT_DONE && w_next == WAIT_DONE) ? r_cnt + 1'b1 : r_cnt;
         r_done_q      <= rtc_done;
         r_done_sticky <= (r_done_sticky && !w_clr) || w_set_done;
         r_err         <= (r_err && !w_clr) || w_set_err;
         r_ovr         <= (r_ovr && !w_clr) || w_set_ovr;
      end
   end

   assign In_Port = r_in_port;
   assign wr_bus  = r_wr_bus;
endmodule

// File: tb/tb_rtc_port_regbank_p.sv
// tb_rtc_port_regbank_p: directed scenarios plus randomized traffic against a
// behavioural model of the register bank.
module tb_rtc_port_regbank_p;
   localparam int NCH = 9;
   localparam int TO  = 1023;

   logic        clk = 0, reset = 0, write = 0, read_strobe = 0, rtc_done = 0;
   logic [7:0]  Port_ID = 0, Out_Port = 0, In_Port;
   logic [71:0] rd_bus = '0, wr_bus;
   logic        commit_req, Listo_esc;
   int          checks = 0, errors = 0;

   always #5 clk = ~clk;

   rtc_port_regbank_p dut (
      .clk(clk), .reset(reset), .write(write), .read_strobe(read_strobe),
      .Port_ID(Port_ID), .Out_Port(Out_Port), .In_Port(In_Port),
      .rd_bus(rd_bus), .rtc_done(rtc_done), .wr_bus(wr_bus),
      .commit_req(commit_req), .Listo_esc(Listo_esc)
   );

   // model state: busy plus age = edges since the accepted commit
   byte unsigned m_sh[NCH], m_wr[NCH], m_snap[NCH];
   logic [7:0]   m_in;
   bit           m_done, m_err, m_ovr, m_sv, m_busy, m_prev;
   int           m_age;

   task automatic chk(input string tag, input logic [71:0] got, input logic [71:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [71:0] m_wr_flat();
      logic [71:0] v;
      for (int i = 0; i < NCH; i++) v[i*8 +: 8] = m_wr[i];
      return v;
   endfunction

   function automatic logic [7:0] m_status();
      return {3'b0, m_err, m_ovr, m_sv, m_done, m_busy};
   endfunction

   task automatic model_reset();
      for (int i = 0; i < NCH; i++) begin m_sh[i] = 0; m_wr[i] = 0; m_snap[i] = 0; end
      {m_done, m_err, m_ovr, m_sv, m_busy, m_prev} = '0;
      m_age = 0;
      m_in  = 0;
   endtask

   task automatic model_step();
      logic [7:0] nin;
      bit rise, ctrl, cmt, snp, clr, ob, sd, se, so;
      if (!reset) begin model_reset(); return; end
      nin = 0;
      if (Port_ID >= 8'h0C && Port_ID <= 8'h14) nin = m_snap[Port_ID - 8'h0C];
      else if (Port_ID == 8'h15) nin = m_status();
      rise = rtc_done && !m_prev;
      ctrl = write && Port_ID == 8'h0B;
      cmt  = ctrl && Out_Port[0];
      snp  = ctrl && Out_Port[1];
      clr  = read_strobe && Port_ID == 8'h15;
      ob   = m_busy;
      {sd, se, so} = '0;
      if (m_busy) begin
         if (m_age >= 2 && rise) begin sd = 1; m_busy = 0; end
         else if (m_age == TO + 2) begin se = 1; m_busy = 0; end
         else m_age++;
      end
      if (cmt) begin
         if (!ob) begin
            for (int i = 0; i < NCH; i++) m_wr[i] = m_sh[i];
            m_busy = 1;
            m_age  = 1;
         end else so = 1;
      end
      if (write && Port_ID >= 8'h02 && Port_ID <= 8'h0A) m_sh[Port_ID - 8'h02] = Out_Port;
      if (snp) begin
         for (int i = 0; i < NCH; i++) m_snap[i] = rd_bus[i*8 +: 8];
         m_sv = 1;
      end
      m_done = (m_done && !clr) || sd;
      m_err  = (m_err && !clr) || se;
      m_ovr  = (m_ovr && !clr) || so;
      m_prev = rtc_done;
      m_in   = nin;
   endtask

   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
      chk("in_port", In_Port, m_in);
      chk("wr_bus", wr_bus, m_wr_flat());
      chk("commit_req", commit_req, m_busy && m_age == 1);
      chk("listo_esc", Listo_esc, !m_busy);
   endtask

   task automatic wr(input logic [7:0] a, input logic [7:0] d);
      write = 1; Port_ID = a; Out_Port = d;
      tick();
      write = 0;
   endtask

   task automatic rd(input logic [7:0] a);
      Port_ID = a;
      tick();
   endtask

   task automatic wait_idle(output int n);
      n = 0;
      while (!Listo_esc && n < 3000) begin tick(); n++; end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int n;
      model_reset();
      tick(); tick();
      reset = 1;
      tick();
      chk("rst_in_port", In_Port, 0);
      chk("rst_wr_bus", wr_bus, 0);
      chk("rst_commit_req", commit_req, 0);
      chk("rst_listo", Listo_esc, 1);
      rd(8'h15);
      chk("rst_status", In_Port, 8'h00);

      wr(8'h02, 8'h13);
      wr(8'h0A, 8'h57);
      chk("shadow_no_commit", wr_bus, 0);
      wr(8'h0B, 8'h01);
      chk("commit_ch0", wr_bus[7:0], 8'h13);
      chk("commit_ch8", wr_bus[71:64], 8'h57);
      chk("commit_pulse", commit_req, 1);
      chk("commit_busy", Listo_esc, 0);
      tick();
      chk("commit_pulse_end", commit_req, 0);

      wr(8'h0B, 8'h01);
      chk("ovr_wr_bus_hold", wr_bus[7:0], 8'h13);
      rtc_done = 1;
      tick();
      chk("done_idle", Listo_esc, 1);
      rd(8'h15);
      chk("status_done_ovr", In_Port, 8'h0A);
      read_strobe = 1;
      tick();
      read_strobe = 0;
      tick();
      chk("status_cleared", In_Port, 8'h00);
      rtc_done = 0;

      rd_bus[47:40] = 8'h43;
      wr(8'h0B, 8'h02);
      rd_bus[47:40] = 8'h44;
      rd(8'h11);
      chk("snap_ch5", In_Port, 8'h43);
      rd(8'h15);
      chk("snap_valid", In_Port, 8'h04);

      wr(8'h0B, 8'h01);
      wait_idle(n);
      chk("timeout_cycles", n, TO + 2);
      rd(8'h15);
      chk("timeout_err", In_Port, 8'h14);
      read_strobe = 1; tick(); read_strobe = 0;
      rtc_done = 1;
      tick();
      wr(8'h0B, 8'h01);
      wait_idle(n);
      chk("timeout_done_high", n, TO + 2);
      rd(8'h15);
      chk("timeout_err_high", In_Port, 8'h14);
      read_strobe = 1; tick(); read_strobe = 0;
      rtc_done = 0;

      wr(8'h0B, 8'h01);
      tick(); tick();
      #3 reset = 0;
      #1;
      chk("async_rst_listo", Listo_esc, 1);
      chk("async_rst_wr_bus", wr_bus, 0);
      chk("async_rst_commit", commit_req, 0);
      model_reset();
      tick();
      reset = 1;
      rd(8'hFF);
      chk("unmapped_ff", In_Port, 0);

      for (int k = 0; k < 4000; k++) begin
         write       = $urandom_range(0, 2) == 0;
         read_strobe = $urandom_range(0, 3) == 0;
         Port_ID     = $urandom_range(0, 3) == 0 ? 8'($urandom) : 8'($urandom_range(2, 8'h15));
         Out_Port    = 8'($urandom);
         if ($urandom_range(0, 9) == 0) rtc_done = ~rtc_done;
         if ($urandom_range(0, 7) == 0) rd_bus = 72'({$urandom, $urandom, $urandom});
         reset = $urandom_range(0, 499) != 0;
         tick();
      end
      reset = 1;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
